// File: rtl/clock_gen_pkg.sv
// Shared types and helpers for the multi-channel clock generator.
// The optional phase-offset feature is controlled by CLOCK_GEN_PHASE_EN
// (see clock_gen_channel / clock_gen_multi).
package clock_gen_pkg;

  // Default counter width; the modules carry their own CNT_WIDTH parameter.
  localparam int CLOCK_GEN_CNT_WIDTH = 8;
  localparam int CLOCK_GEN_N_CHANNELS = 4;

  typedef logic [CLOCK_GEN_CNT_WIDTH-1:0] cnt_t;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_DUTY   = 1'b1
  } mode_e;

  // Number of high cycles in duty mode: ceil(k/2).
  function automatic int unsigned half_up(input int unsigned k);
    return (k + 1) >> 1;
  endfunction

endpackage

// File: rtl/clock_gen_channel.sv
// One programmable clock channel: mod-k counter, reload shadow and
// registered clock / rollover outputs.
// Optional macro CLOCK_GEN_PHASE_EN adds phase_i: immediate reloads then
// start counting from phase_i reduced into 0..k-1.
module clock_gen_channel
  import clock_gen_pkg::*;
#(
  parameter int CNT_WIDTH = CLOCK_GEN_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 enable_i,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] div_i,
  input  logic                 mode_i,
`ifdef CLOCK_GEN_PHASE_EN
  input  logic [CNT_WIDTH-1:0] phase_i,
`endif
  output logic                 clk_o,
  output logic                 roll_over_o
);

  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] k_act_q, k_act_d;
  mode_e                mode_act_q, mode_act_d;
  logic [CNT_WIDTH-1:0] shadow_k_q, shadow_k_d;
  mode_e                shadow_mode_q, shadow_mode_d;
  logic                 pend_q, pend_d;
  logic                 clk_q, clk_d;
  logic                 roll_q, roll_d;

  logic                 active;
  logic                 wrap;
  logic                 pend_eff;
  logic                 apply;
  logic [CNT_WIDTH-1:0] k_eff;
  mode_e                mode_eff;
  logic [CNT_WIDTH-1:0] half_eff;
  logic [CNT_WIDTH-1:0] start_cnt;

  // Next-state logic: counter, reload handshake and output clock rule.
  always_comb begin
    active = enable_i && (k_act_q != '0);
    wrap   = active && (cnt_q == (k_act_q - ONE));

    // A load on this edge counts as pending right now, so a load that
    // coincides with a wrap (or with an idle channel) applies immediately.
    shadow_k_d    = load_i ? div_i : shadow_k_q;
    shadow_mode_d = load_i ? mode_e'(mode_i) : shadow_mode_q;
    pend_eff      = load_i || pend_q;

    // Apply only at a period boundary, or when no period is running, so
    // a running period is never cut short or stretched.
    apply    = pend_eff && (wrap || !active);
    k_eff    = apply ? shadow_k_d : k_act_q;
    mode_eff = apply ? shadow_mode_d : mode_act_q;

    k_act_d    = k_eff;
    mode_act_d = mode_eff;
    pend_d     = pend_eff && !apply;

    half_eff = CNT_WIDTH'(half_up(32'(k_eff)));

`ifdef CLOCK_GEN_PHASE_EN
    // Reduce the requested phase into range with one compare-subtract;
    // anything still out of range is clamped to the last count.
    start_cnt = phase_i;
    if (k_eff == '0) begin
      start_cnt = '0;
    end else if (phase_i >= k_eff) begin
      start_cnt = phase_i - k_eff;
      if (start_cnt >= k_eff) begin
        start_cnt = k_eff - ONE;
      end
    end
`else
    start_cnt = '0;
`endif

    if (apply && !active) begin
      cnt_d = start_cnt;
    end else if (wrap) begin
      cnt_d = '0;
    end else if (active) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end

    roll_d = wrap;

    // Toggle mode flips only on a wrap; duty mode re-evaluates whenever the
    // channel counts or a new setting is applied. k=0 leaves the clock held.
    clk_d = clk_q;
    if (mode_eff == MODE_TOGGLE) begin
      if (wrap) begin
        clk_d = ~clk_q;
      end
    end else if ((k_eff != '0) && (active || apply)) begin
      clk_d = (cnt_d < half_eff);
    end
  end

  // State registers with synchronous reset; reset wins over load/enable.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q         <= '0;
      k_act_q       <= '0;
      mode_act_q    <= MODE_TOGGLE;
      shadow_k_q    <= '0;
      shadow_mode_q <= MODE_TOGGLE;
      pend_q        <= 1'b0;
      clk_q         <= 1'b1;
      roll_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      k_act_q       <= k_act_d;
      mode_act_q    <= mode_act_d;
      shadow_k_q    <= shadow_k_d;
      shadow_mode_q <= shadow_mode_d;
      pend_q        <= pend_d;
      clk_q         <= clk_d;
      roll_q        <= roll_d;
    end
  end

  assign clk_o       = clk_q;
  assign roll_over_o = roll_q;

endmodule

// File: rtl/clock_gen_multi.sv
// N-channel programmable clock generator. Each channel is an independent
// clock_gen_channel fed from its slice of the packed configuration buses.
// Optional macro CLOCK_GEN_PHASE_EN adds the i_phase port (per-channel
// start count on immediate reloads).
module clock_gen_multi
  import clock_gen_pkg::*;
#(
  parameter int N_CHANNELS = CLOCK_GEN_N_CHANNELS,
  parameter int CNT_WIDTH  = CLOCK_GEN_CNT_WIDTH
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [N_CHANNELS-1:0]           i_enable,
  input  logic [N_CHANNELS-1:0]           i_load,
  input  logic [N_CHANNELS*CNT_WIDTH-1:0] i_div,
  input  logic [N_CHANNELS-1:0]           i_mode,
`ifdef CLOCK_GEN_PHASE_EN
  input  logic [N_CHANNELS*CNT_WIDTH-1:0] i_phase,
`endif
  output logic [N_CHANNELS-1:0]           o_clk,
  output logic [N_CHANNELS-1:0]           o_roll_over
);

  for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_ch
    clock_gen_channel #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_channel (
      .clk_i       (i_clk),
      .srst_i      (i_reset),
      .enable_i    (i_enable[gi]),
      .load_i      (i_load[gi]),
      .div_i       (i_div[gi*CNT_WIDTH +: CNT_WIDTH]),
      .mode_i      (i_mode[gi]),
`ifdef CLOCK_GEN_PHASE_EN
      .phase_i     (i_phase[gi*CNT_WIDTH +: CNT_WIDTH]),
`endif
      .clk_o       (o_clk[gi]),
      .roll_over_o (o_roll_over[gi])
    );
  end

endmodule

// File: tb/tb_clock_gen_multi.sv
// Self-checking bench for clock_gen_multi: directed scenarios plus a long
// randomized run, all compared cycle by cycle against a behavioural model.
module tb_clock_gen_multi;

  localparam int N = 4;
  localparam int W = 8;

  logic           i_clk = 1'b0;
  logic           i_reset;
  logic [N-1:0]   i_enable;
  logic [N-1:0]   i_load;
  logic [N*W-1:0] i_div;
  logic [N-1:0]   i_mode;
`ifdef CLOCK_GEN_PHASE_EN
  logic [N*W-1:0] i_phase;
`endif
  logic [N-1:0]   o_clk;
  logic [N-1:0]   o_roll_over;

  clock_gen_multi #(.N_CHANNELS(N), .CNT_WIDTH(W)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_load      (i_load),
    .i_div       (i_div),
    .i_mode      (i_mode),
`ifdef CLOCK_GEN_PHASE_EN
    .i_phase     (i_phase),
`endif
    .o_clk       (o_clk),
    .o_roll_over (o_roll_over)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: per channel, the count position inside the period,
  // the active divisor/mode, the pending request and the output levels.
  int m_cnt[N];
  int m_k[N];
  int m_mode[N];   // 0 toggle, 1 duty
  int m_sk[N];
  int m_smode[N];
  bit m_pend[N];
  bit m_clk[N];
  bit m_roll[N];

  function automatic int phase_of(int c);
`ifdef CLOCK_GEN_PHASE_EN
    return int'(i_phase[c*W +: W]);
`else
    return c - c;
`endif
  endfunction

  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      if (i_reset) begin
        m_cnt[c] = 0; m_k[c] = 0; m_mode[c] = 0; m_sk[c] = 0; m_smode[c] = 0;
        m_pend[c] = 0; m_clk[c] = 1; m_roll[c] = 0;
      end else begin
        bit running, wraps, applies;
        int nxt;
        running = i_enable[c] && (m_k[c] != 0);
        wraps   = running && (m_cnt[c] == m_k[c] - 1);
        if (i_load[c]) begin
          m_sk[c] = int'(i_div[c*W +: W]);
          m_smode[c] = int'(i_mode[c]);
          m_pend[c] = 1;
        end
        applies = m_pend[c] && (wraps || !running);
        nxt = running ? (wraps ? 0 : m_cnt[c] + 1) : m_cnt[c];
        if (applies) begin
          m_k[c] = m_sk[c];
          m_mode[c] = m_smode[c];
          m_pend[c] = 0;
          if (!running) nxt = (m_k[c] == 0) ? 0 : phase_of(c) % m_k[c];
        end
        if (m_mode[c] == 0) begin
          if (wraps) m_clk[c] = !m_clk[c];
        end else if (m_k[c] != 0 && (running || applies)) begin
          m_clk[c] = (nxt < (m_k[c] + 1) / 2);
        end
        m_cnt[c] = nxt;
        m_roll[c] = wraps;
      end
    end
  endtask

  // One clock: update the model with the inputs seen at the edge, then
  // compare every channel's outputs shortly after the edge.
  task automatic tick();
    @(posedge i_clk);
    model_step();
    #1;
    for (int c = 0; c < N; c++) begin
      chk($sformatf("ch%0d_clk", c), 32'(o_clk[c]), 32'(m_clk[c]));
      chk($sformatf("ch%0d_roll", c), 32'(o_roll_over[c]), 32'(m_roll[c]));
    end
  endtask

  task automatic set_load(input int c, input int k, input bit mode);
    i_load[c] = 1'b1;
    i_div[c*W +: W] = W'(k);
    i_mode[c] = mode;
  endtask

  logic [6:0] tog_clk_exp;
  logic [6:0] tog_roll_exp;
  logic [6:0] duty_clk_exp;

  initial begin
    i_reset  = 1'b1;
    i_enable = '0;
    i_load   = '1;          // loads during reset must be ignored
    i_div    = {N{8'd3}};
    i_mode   = '0;
`ifdef CLOCK_GEN_PHASE_EN
    i_phase  = '0;
`endif
    for (int i = 0; i < 3; i++) tick();
    chk("rst_clk", 32'(o_clk), 32'({N{1'b1}}));
    chk("rst_roll", 32'(o_roll_over), 32'h0);

    // Idle after reset: nothing loaded, so all channels stay stalled.
    i_reset = 1'b0;
    i_load = '0;
    i_enable = '1;
    for (int i = 0; i < 20; i++) tick();
    chk("idle_clk", 32'(o_clk), 32'({N{1'b1}}));

    // ch0 toggle k=3, ch1 duty k=4, expected sample sequences from the load edge.
    tog_clk_exp  = 7'b1000111;   // bit i = sample i: 1,1,1,0,0,0,1
    tog_roll_exp = 7'b1001000;   // rollovers at samples 3 and 6
    duty_clk_exp = 7'b0110011;   // 1,1,0,0,1,1,0
    set_load(0, 3, 1'b0);
    set_load(1, 4, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick();
      i_load = '0;
      chk("ch0_tog_seq", 32'(o_clk[0]), 32'(tog_clk_exp[i]));
      chk("ch0_roll_seq", 32'(o_roll_over[0]), 32'(tog_roll_exp[i]));
      chk("ch1_duty_seq", 32'(o_clk[1]), 32'(duty_clk_exp[i]));
    end
    for (int i = 0; i < 6; i++) tick();

    // ch1 reload to duty k=5 while running: takes effect at its next wrap.
    set_load(1, 5, 1'b1);
    tick();
    i_load = '0;
    for (int i = 0; i < 15; i++) tick();

    // ch0 at cnt=1 gets k=5: current period completes, then spacing of 5.
    for (int i = 0; i < 10 && m_cnt[0] != 1; i++) tick();
    chk("ch0_found_cnt1", 32'(m_cnt[0]), 32'd1);
    set_load(0, 5, 1'b0);
    tick();
    i_load = '0;
    for (int i = 0; i < 20; i++) tick();

    // Pause ch0 mid-period for 4 cycles, then resume.
    tick(); tick();
    i_enable[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    i_enable[0] = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    // k=0 stalls ch0.
    set_load(0, 0, 1'b0);
    tick();
    i_load = '0;
    for (int i = 0; i < 12; i++) tick();
    chk("stall_roll", 32'(o_roll_over[0]), 32'h0);

    // One-cycle reset mid-run with loads active.
    set_load(2, 2, 1'b0);
    tick();
    i_load = '0;
    for (int i = 0; i < 5; i++) tick();
    i_reset = 1'b1;
    i_load = '1;
    tick();
    i_reset = 1'b0;
    i_load = '0;
    for (int i = 0; i < 10; i++) tick();
    chk("post_rst_clk", 32'(o_clk), 32'({N{1'b1}}));
    chk("post_rst_roll", 32'(o_roll_over), 32'h0);

`ifdef CLOCK_GEN_PHASE_EN
    // ch0/ch1 k=4 toggle with phases 0 and 2: ch1 leads ch0 by 2 cycles.
    i_phase = '0;
    i_phase[1*W +: W] = 8'd2;
    set_load(0, 4, 1'b0);
    set_load(1, 4, 1'b0);
    tick();
    i_load = '0;
    tick();
    tick();
    chk("phase_ch1_roll", 32'(o_roll_over[1]), 32'h1);
    chk("phase_ch0_roll", 32'(o_roll_over[0]), 32'h0);
    tick();
    tick();
    chk("phase_ch0_roll_late", 32'(o_roll_over[0]), 32'h1);
    for (int i = 0; i < 10; i++) tick();
`endif

    // Randomized run.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      i_reset = ($urandom_range(0, 399) == 0);
      for (int c = 0; c < N; c++) begin
        i_enable[c] = ($urandom_range(0, 9) != 0);
        i_load[c]   = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 15) == 0)
          i_div[c*W +: W] = W'($urandom_range(0, 40));
        else
          i_div[c*W +: W] = W'($urandom_range(0, 6));
        i_mode[c] = 1'($urandom_range(0, 1));
`ifdef CLOCK_GEN_PHASE_EN
        i_phase[c*W +: W] = W'($urandom_range(0, 1));
`endif
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
